// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - round-robin arbiter sharing one bus port among three DMA requesters
//
// Requesters: 0 = descriptor fetch, 1 = data read, 2 = data write.
// Ports:
//   clk, rstb                      clock, asynchronous active-low reset
//   {desc,rd,wr}_req/_addr/_len    request held until the matching *_ack
//   {desc,rd,wr}_ack               one-cycle pulse once the bus accepts the request
//   bus_req/_addr/_len/_wr/_src    latched request presented to the bus interface
//   bus_ack, bus_done              single-cycle accept and completion strobes from the bus
//   busy                           high whenever the FSM is not in IDLE
//   bus_timeout, clr_timeout       sticky watchdog abort flag and its clear
module dma_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        desc_req,
  input  logic [31:0] desc_addr,
  input  logic [7:0]  desc_len,
  output logic        desc_ack,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  input  logic [7:0]  rd_len,
  output logic        rd_ack,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [7:0]  wr_len,
  output logic        wr_ack,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [7:0]  bus_len,
  output logic        bus_wr,
  output logic [1:0]  bus_src,
  input  logic        bus_ack,
  input  logic        bus_done,
  output logic        busy,
  output logic        bus_timeout,
  input  logic        clr_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  localparam logic [16:0] TIMEOUT_W  = 17'(TIMEOUT_CYCLES);
  localparam bit          WD_ENABLED = (TIMEOUT_CYCLES != 0);

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  ack_q, ack_d;          // {wr, rd, desc}
  logic        bus_req_q, bus_req_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_len_q, bus_len_d;
  logic        bus_wr_q, bus_wr_d;
  logic [1:0]  bus_src_q, bus_src_d;
  logic        busy_q, busy_d;
  logic        bus_timeout_q, bus_timeout_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;

  logic        any_req;
  logic [1:0]  winner;
  logic        wd_hit;
  logic        timeout_set;

  assign any_req = desc_req | rd_req | wr_req;

  // Scan starts at rr_ptr and wraps mod 3; first active requester wins.
  always_comb begin
    winner = 2'd0;
    case (rr_ptr_q)
      2'd1: begin
        if (rd_req)        winner = 2'd1;
        else if (wr_req)   winner = 2'd2;
        else               winner = 2'd0;
      end
      2'd2: begin
        if (wr_req)        winner = 2'd2;
        else if (desc_req) winner = 2'd0;
        else               winner = 2'd1;
      end
      default: begin
        if (desc_req)      winner = 2'd0;
        else if (rd_req)   winner = 2'd1;
        else               winner = 2'd2;
      end
    endcase
  end

  // The counter holds the number of ISSUE/WAIT_DONE cycles already spent, so
  // the abort fires on the cycle that would make the total reach the limit.
  assign wd_hit = WD_ENABLED && (({1'b0, wd_cnt_q} + 17'd1) == TIMEOUT_W);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    ack_d       = 3'b000;
    bus_req_d   = bus_req_q;
    bus_addr_d  = bus_addr_q;
    bus_len_d   = bus_len_q;
    bus_wr_d    = bus_wr_q;
    bus_src_d   = bus_src_q;
    wd_cnt_d    = wd_cnt_q;
    timeout_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          case (winner)
            2'd1: begin
              bus_addr_d = rd_addr;
              bus_len_d  = rd_len;
            end
            2'd2: begin
              bus_addr_d = wr_addr;
              bus_len_d  = wr_len;
            end
            default: begin
              bus_addr_d = desc_addr;
              bus_len_d  = desc_len;
            end
          endcase
          bus_src_d = winner;
          bus_wr_d  = (winner == 2'd2);
          bus_req_d = 1'b1;
          wd_cnt_d  = 16'd0;
          state_d   = ISSUE;
        end
      end

      ISSUE: begin
        wd_cnt_d = wd_cnt_q + 16'd1;
        // bus_ack takes precedence over a coincident watchdog expiry.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          ack_d     = 3'b001 << bus_src_q;
          rr_ptr_d  = (bus_src_q == 2'd2) ? 2'd0 : bus_src_q + 2'd1;
          state_d   = WAIT_DONE;
        end else if (wd_hit) begin
          // No ack: the requester keeps its req up and is re-arbitrated.
          bus_req_d   = 1'b0;
          timeout_set = 1'b1;
          state_d     = GAP;
        end
      end

      WAIT_DONE: begin
        wd_cnt_d = wd_cnt_q + 16'd1;
        if (bus_done) begin
          state_d = GAP;
        end else if (wd_hit) begin
          timeout_set = 1'b1;
          state_d     = GAP;
        end
      end

      GAP: begin
        // One dead cycle so a registered requester has dropped req before
        // the next scan; otherwise it would be granted twice.
        bus_src_d = 2'b11;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d        = (state_d != IDLE);
    bus_timeout_d = timeout_set | (bus_timeout_q & ~clr_timeout);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 2'd0;
      ack_q         <= 3'b000;
      bus_req_q     <= 1'b0;
      bus_addr_q    <= 32'd0;
      bus_len_q     <= 8'd0;
      bus_wr_q      <= 1'b0;
      bus_src_q     <= 2'b11;
      busy_q        <= 1'b0;
      bus_timeout_q <= 1'b0;
      wd_cnt_q      <= 16'd0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      ack_q         <= ack_d;
      bus_req_q     <= bus_req_d;
      bus_addr_q    <= bus_addr_d;
      bus_len_q     <= bus_len_d;
      bus_wr_q      <= bus_wr_d;
      bus_src_q     <= bus_src_d;
      busy_q        <= busy_d;
      bus_timeout_q <= bus_timeout_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign desc_ack    = ack_q[0];
  assign rd_ack      = ack_q[1];
  assign wr_ack      = ack_q[2];
  assign bus_req     = bus_req_q;
  assign bus_addr    = bus_addr_q;
  assign bus_len     = bus_len_q;
  assign bus_wr      = bus_wr_q;
  assign bus_src     = bus_src_q;
  assign busy        = busy_q;
  assign bus_timeout = bus_timeout_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - directed self-checking bench for dma_bus_arbiter
module tb_dma_bus_arbiter;

  logic        clk = 1'b0;
  logic        rstb;
  logic        desc_req, rd_req, wr_req;
  logic [31:0] desc_addr, rd_addr, wr_addr;
  logic [7:0]  desc_len, rd_len, wr_len;
  logic        desc_ack, rd_ack, wr_ack;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [7:0]  bus_len;
  logic        bus_wr;
  logic [1:0]  bus_src;
  logic        bus_ack, bus_done;
  logic        busy, bus_timeout, clr_timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_addr [3] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
  logic [7:0]  exp_len  [3] = '{8'd4, 8'd8, 8'd16};

  dma_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rstb(rstb),
    .desc_req(desc_req), .desc_addr(desc_addr), .desc_len(desc_len), .desc_ack(desc_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_len(bus_len), .bus_wr(bus_wr),
    .bus_src(bus_src), .bus_ack(bus_ack), .bus_done(bus_done),
    .busy(busy), .bus_timeout(bus_timeout), .clr_timeout(clr_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic reset_dut;
    rstb = 1'b0;
    tick;
    tick;
    rstb = 1'b1;
    tick;
  endtask

  task automatic wait_req(output int t);
    int n = 0;
    while (!bus_req && n < 30) begin
      tick;
      n++;
    end
    chk("bus_req_seen", bus_req, 1);
    t = cyc;
  endtask

  // Immediate ack and done; optionally the requester drops req on its ack.
  task automatic do_grant(input logic [1:0] s, input bit drop, output int t);
    wait_req(t);
    chk("grant_src", bus_src, s);
    chk("grant_wr", bus_wr, (s == 2'd2));
    chk("grant_addr", bus_addr, exp_addr[s]);
    chk("grant_len", bus_len, exp_len[s]);
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    chk("ack_vec", {wr_ack, rd_ack, desc_ack}, 3'b001 << s);
    chk("bus_req_drop", bus_req, 0);
    if (drop) begin
      case (s)
        2'd0:    desc_req = 1'b0;
        2'd1:    rd_req   = 1'b0;
        default: wr_req   = 1'b0;
      endcase
    end
    bus_done = 1'b1;
    tick;
    bus_done = 1'b0;
    chk("ack_single", {wr_ack, rd_ack, desc_ack}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int t, t_prev, n, acks;
    bit seen;
    rstb = 1'b0;
    desc_req = 0; rd_req = 0; wr_req = 0;
    desc_addr = exp_addr[0]; rd_addr = exp_addr[1]; wr_addr = exp_addr[2];
    desc_len = exp_len[0]; rd_len = exp_len[1]; wr_len = exp_len[2];
    bus_ack = 0; bus_done = 0; clr_timeout = 0;
    tick;
    tick;

    // reset values
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_src", bus_src, 2'b11);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", bus_timeout, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_len", bus_len, 0);
    chk("rst_wr", bus_wr, 0);
    chk("rst_acks", {wr_ack, rd_ack, desc_ack}, 0);
    rstb = 1'b1;
    tick;

    // single request with delayed ack/done; addr change mid-grant ignored
    desc_req = 1'b1;
    tick;
    chk("t1_bus_req", bus_req, 1);
    chk("t1_addr", bus_addr, 32'h1000);
    chk("t1_len", bus_len, 4);
    chk("t1_wr", bus_wr, 0);
    chk("t1_src", bus_src, 0);
    chk("t1_busy", busy, 1);
    tick;
    tick;
    chk("t1_req_held", bus_req, 1);
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    chk("t1_desc_ack", desc_ack, 1);
    chk("t1_req_low", bus_req, 0);
    desc_req = 1'b0;
    desc_addr = 32'hDEAD_0000;
    tick;
    chk("t1_ack_pulse", desc_ack, 0);
    chk("t1_addr_latched", bus_addr, 32'h1000);
    tick;
    tick;
    bus_done = 1'b1;
    tick;
    bus_done = 1'b0;
    chk("t1_gap_busy", busy, 1);
    chk("t1_no_timeout", bus_timeout, 0);
    tick;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_src", bus_src, 2'b11);
    desc_addr = exp_addr[0];

    // round robin with all three requests held
    reset_dut;
    desc_req = 1; rd_req = 1; wr_req = 1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_grant(2'(i % 3), 1'b0, t);
      if (i > 0) chk("rr_spacing", t - t_prev, 4);
      t_prev = t;
    end
    desc_req = 0; rd_req = 0; wr_req = 0;
    tick;
    tick;
    chk("rr_idle", busy, 0);

    // rotation: after rd, wr beats desc
    rd_req = 1'b1;
    do_grant(2'd1, 1'b1, t);
    desc_req = 1'b1;
    wr_req = 1'b1;
    do_grant(2'd2, 1'b1, t);
    do_grant(2'd0, 1'b1, t);
    tick;
    tick;

    // watchdog abort in ISSUE
    reset_dut;
    desc_req = 1'b1;
    tick;
    n = 0;
    seen = 0;
    while (bus_req && n < 40) begin
      if (desc_ack) seen = 1;
      n++;
      tick;
    end
    chk("to_issue_len", n, 8);
    chk("to_issue_flag", bus_timeout, 1);
    chk("to_issue_gap_busy", busy, 1);
    chk("to_issue_no_ack", {seen, desc_ack}, 0);
    do_grant(2'd0, 1'b1, t);
    chk("to_sticky", bus_timeout, 1);
    clr_timeout = 1'b1;
    tick;
    clr_timeout = 1'b0;
    chk("to_cleared", bus_timeout, 0);

    // watchdog abort in WAIT_DONE
    rd_req = 1'b1;
    wait_req(t);
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    chk("tw_rd_ack", rd_ack, 1);
    rd_req = 1'b0;
    acks = 1;
    n = 0;
    while (!bus_timeout && n < 40) begin
      tick;
      n++;
      if (desc_ack | rd_ack | wr_ack) acks++;
    end
    chk("tw_len", n, 7);
    chk("tw_flag", bus_timeout, 1);
    chk("tw_one_ack", acks, 1);
    chk("tw_gap_busy", busy, 1);
    tick;
    chk("tw_idle_busy", busy, 0);
    chk("tw_idle_src", bus_src, 2'b11);
    clr_timeout = 1'b1;
    tick;
    clr_timeout = 1'b0;

    // asynchronous reset while in WAIT_DONE
    wr_req = 1'b1;
    wait_req(t);
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    chk("rs_wr_ack", wr_ack, 1);
    wr_req = 1'b0;
    tick;
    chk("rs_busy_before", busy, 1);
    #2;
    rstb = 1'b0;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_src", bus_src, 2'b11);
    chk("rs_addr", bus_addr, 0);
    chk("rs_len", bus_len, 0);
    chk("rs_wr", bus_wr, 0);
    chk("rs_bus_req", bus_req, 0);
    chk("rs_acks", {wr_ack, rd_ack, desc_ack}, 0);
    tick;
    rstb = 1'b1;
    desc_req = 1; rd_req = 1; wr_req = 1;
    do_grant(2'd0, 1'b1, t);
    rd_req = 0;
    wr_req = 0;
    tick;
    tick;
    chk("rs_final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Shares the single bus-interface port among three DMA requesters: descriptor fetch (index 0), data read (1) and data write (2).
- Uses round-robin grant order and latches the winner's address, length and direction onto the bus.
- Holds the grant until the bus reports completion, then releases it.
- A watchdog aborts a grant when the bus never acknowledges or never completes, and raises a sticky error flag.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles allowed in ISSUE plus WAIT_DONE before abort. 0 disables the watchdog. Range 0..65535.

Ports:
- clk  in  1  system clock
- rstb  in  1  asynchronous active-low reset
- desc_req  in  1  descriptor fetch request; held until desc_ack
- desc_addr  in  32  descriptor address
- desc_len  in  8  descriptor length in dwords
- desc_ack  out  1  one-cycle pulse: request accepted by bus
- rd_req, rd_addr, rd_len, rd_ack  in/in/in/out  1/32/8/1  data-read requester, same semantics
- wr_req, wr_addr, wr_len, wr_ack  in/in/in/out  1/32/8/1  data-write requester, same semantics
- bus_req  out  1  request to bus interface
- bus_addr  out  32  latched address of the granted requester
- bus_len  out  8  latched length of the granted requester
- bus_wr  out  1  1 = write transfer (granted index 2)
- bus_src  out  2  granted index (0/1/2); 2'b11 when no grant
- bus_ack  in  1  bus accepted the request (single-cycle)
- bus_done  in  1  transfer complete (single-cycle)
- busy  out  1  high in every state except IDLE
- bus_timeout  out  1  sticky watchdog error flag
- clr_timeout  in  1  clears bus_timeout

Behaviour:
- Reset:
  - state = IDLE, rr_ptr = 0.
  - All ack outputs, bus_req, bus_wr, busy and bus_timeout = 0.
  - bus_addr = 0, bus_len = 0, bus_src = 2'b11, watchdog counter = 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - If any request is high, scan indices starting at rr_ptr, wrapping mod 3; the first requester found wins.
  - Latch the winner's addr/len, set bus_wr = (winner == 2), set bus_src = winner, set bus_req = 1 on the next cycle, go to ISSUE.
  - If no request is high, stay in IDLE.
- ISSUE:
  - bus_req is held high.
  - On bus_ack: bus_req drops next cycle, the winner's *_ack pulses for exactly one cycle (the cycle after bus_ack is sampled), rr_ptr = (winner + 1) mod 3, go to WAIT_DONE.
- WAIT_DONE:
  - On bus_done go to GAP.
  - bus_done in any other state is ignored.
  - bus_ack in any state other than ISSUE is ignored.
- GAP:
  - Lasts exactly one cycle; bus_src returns to 2'b11, then go to IDLE.
  - This guarantees a registered requester has dropped its req before re-arbitration, so the same request is never granted twice.
- Latency: a request first seen in IDLE produces bus_req 1 cycle later. The minimum grant-to-next-grant spacing is ISSUE(1) + WAIT_DONE(1) + GAP(1) + IDLE(1) = 4 cycles.
- Requests changing while a grant is held do not alter bus_addr/bus_len/bus_wr; these are latched only in IDLE.
- Watchdog:
  - Counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT_DONE.
  - When count == TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): set bus_timeout, drop bus_req, go to GAP.
  - No *_ack is issued when the abort happens in ISSUE; the requester keeps req high and is re-arbitrated. rr_ptr is unchanged in that case.
  - If the timeout and bus_ack coincide in ISSUE, bus_ack wins and the counter is ignored for that cycle.
- bus_timeout stays set until clr_timeout = 1. If clr_timeout and a new timeout coincide, set wins.
- Reset mid-operation returns the block to its reset values immediately (asynchronously); no ack pulse is generated.
- Only one *_ack is ever high at a time. *_ack is never asserted unless the matching req was high at grant.

Test Plan:
- Single request: desc_req = 1, desc_addr = 0x0000_1000, desc_len = 4, bus_ack 3 cycles after bus_req, bus_done 5 cycles later. Expect bus_req one cycle after req, bus_addr = 0x1000, bus_len = 4, bus_wr = 0, bus_src = 0, one desc_ack pulse, busy returns low after GAP.
- Round-robin: all three reqs held high, each bus_ack/bus_done immediate. Expect grant order 0, 1, 2, 0. bus_wr = 1 only on index 2 grants. Consecutive bus_req rises are exactly 4 cycles apart.
- Priority rotation: after granting rd (index 1), raise desc_req and wr_req together. Expect wr (index 2) granted before desc.
- ISSUE timeout: TIMEOUT_CYCLES = 8, never assert bus_ack. Expect bus_req to drop after 8 cycles, bus_timeout = 1, no desc_ack, desc re-granted. clr_timeout clears the flag.
- WAIT_DONE timeout: bus_ack given, bus_done withheld. Expect abort via GAP with bus_timeout = 1 and exactly one ack pulse total.
- Reset mid-grant: assert rstb = 0 while in WAIT_DONE. Expect all outputs at reset values immediately, bus_src = 2'b11, rr_ptr = 0 after release.
